// File: rtl/led_matrix_pwm_scanner.sv
// LED matrix column scanner with per-pixel PWM brightness and a
// double-buffered frame store loaded through a valid/ready handshake.
// The scan counters form the first stage; the row/column drive
// registers form the second, so rows and cols always change together.
module led_matrix_pwm_scanner #(
  parameter int ROWS  = 5,
  parameter int COLS  = 5,
  parameter int BPP   = 2,
  parameter int DWELL = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ena,
  input  logic [ROWS*COLS*BPP-1:0]   frame_in,
  input  logic                       frame_valid,
  output logic                       frame_ready,
  output logic [ROWS-1:0]            rows,
  output logic [COLS-1:0]            cols,
  output logic                       frame_start
);

  localparam int FW      = ROWS * COLS * BPP;
  localparam int PWM_MAX = (1 << BPP) - 2;
  localparam int DIV_W   = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;

  // Scan position (stage p0): prescaler, PWM tick and active column.
  logic [DIV_W-1:0] div_p0;
  logic [BPP-1:0]   pwm_p0;
  logic [COL_W-1:0] col_p0;

  // Frame storage: the scanned image and the pending one.
  logic [FW-1:0] display;
  logic [FW-1:0] shadow;
  logic          shadow_full;

  logic div_wrap;
  logic pwm_wrap;
  logic col_wrap;
  logic boundary;
  logic swap;
  logic xfer;

  // Row pattern of one column: a pixel is lit while its level exceeds the PWM tick.
  function automatic logic [ROWS-1:0] column_lit(input logic [FW-1:0]    img,
                                                 input logic [COL_W-1:0] c,
                                                 input logic [BPP-1:0]   level);
    logic [ROWS-1:0] lit;
    lit = '0;
    for (int i = 0; i < COLS; i++) begin
      if (c == COL_W'(i)) begin
        for (int r = 0; r < ROWS; r++) begin
          lit[r] = img[(i*ROWS + r)*BPP +: BPP] > level;
        end
      end
    end
    return lit;
  endfunction

  // Decode of the scan position: wraps, frame boundary, swap and load strobes.
  always_comb begin
    div_wrap = (div_p0 == DIV_W'(DWELL - 1));
    pwm_wrap = (pwm_p0 == BPP'(PWM_MAX));
    col_wrap = (col_p0 == COL_W'(COLS - 1));
    boundary = ena & div_wrap & pwm_wrap & col_wrap;
    // While disabled there is no frame to protect, so a pending frame swaps at once.
    swap     = shadow_full & (~ena | boundary);
    xfer     = frame_valid & frame_ready;
  end

  // Scan counters: prescaler -> PWM tick -> column, parked at zero when disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_p0 <= '0;
      pwm_p0 <= '0;
      col_p0 <= '0;
    end else if (!ena) begin
      div_p0 <= '0;
      pwm_p0 <= '0;
      col_p0 <= '0;
    end else if (div_wrap) begin
      div_p0 <= '0;
      if (pwm_wrap) begin
        pwm_p0 <= '0;
        col_p0 <= col_wrap ? '0 : col_p0 + 1'b1;
      end else begin
        pwm_p0 <= pwm_p0 + 1'b1;
      end
    end else begin
      div_p0 <= div_p0 + 1'b1;
    end
  end

  // Handshake flag and display buffer; a swap always empties a full shadow,
  // so it can never coincide with a transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_full <= 1'b0;
      frame_ready <= 1'b1;
      display     <= '0;
    end else if (swap) begin
      display     <= shadow;
      shadow_full <= 1'b0;
      frame_ready <= 1'b1;
    end else if (xfer) begin
      shadow_full <= 1'b1;
      frame_ready <= 1'b0;
    end
  end

  // Shadow data capture; only meaningful while shadow_full is set.
  always_ff @(posedge clk) begin
    if (xfer) begin
      shadow <= frame_in;
    end
  end

  // Output drive (stage p1): rows, cols and frame_start registered together.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rows        <= '0;
      cols        <= '0;
      frame_start <= 1'b0;
    end else if (ena) begin
      rows        <= column_lit(display, col_p0, pwm_p0);
      cols        <= COLS'(1) << col_p0;
      frame_start <= (col_p0 == '0) && (pwm_p0 == '0) && (div_p0 == '0);
    end else begin
      rows        <= '0;
      cols        <= '0;
      frame_start <= 1'b0;
    end
  end

endmodule
